// File: rtl/decode_stage_if.sv
// Decode-stage bus: instruction handshake, writeback port and the issue register
// toward the ALU. The slave modport is the decode stage, the master modport its driver.
interface decode_stage_if;
    logic [15:0] I_instr;
    logic        I_instr_valid;
    logic        o_instr_ready;
    logic        I_ex_ready;
    logic        I_flush;
    logic        I_wb_en;
    logic [2:0]  I_wb_sel;
    logic [15:0] I_wb_data;
    logic        o_valid;
    logic [4:0]  o_aluop;
    logic [15:0] o_dataA;
    logic [15:0] o_dataB;
    logic [7:0]  o_imm;
    logic [2:0]  o_selD;
    logic        o_regwe;

    modport slave (
        input  I_instr, I_instr_valid, I_ex_ready, I_flush, I_wb_en, I_wb_sel, I_wb_data,
        output o_instr_ready, o_valid, o_aluop, o_dataA, o_dataB, o_imm, o_selD, o_regwe
    );

    modport master (
        output I_instr, I_instr_valid, I_ex_ready, I_flush, I_wb_en, I_wb_sel, I_wb_data,
        input  o_instr_ready, o_valid, o_aluop, o_dataA, o_dataB, o_imm, o_selD, o_regwe
    );
endinterface

// File: rtl/decode_stage.sv
// Instruction decode with register file, writeback bypass and a busy-bit scoreboard
// that stalls on RAW/WAW hazards; one output register feeds the execute stage.
module decode_stage #(
    parameter int DATA_W  = 16,
    parameter int REG_CNT = 8
) (
    input logic            I_clk,
    input logic            I_rst_n,
    decode_stage_if.slave  bus
);
    localparam int SEL_W = $clog2(REG_CNT);

    logic [3:0]       opcode;
    logic             flag;
    logic [SEL_W-1:0] rd, ra, rb;
    logic [7:0]       imm;

    assign opcode = bus.I_instr[15:12];
    assign rd     = bus.I_instr[11:9];
    assign flag   = bus.I_instr[8];
    assign ra     = bus.I_instr[7:5];
    assign rb     = bus.I_instr[4:2];
    assign imm    = bus.I_instr[7:0];

    logic dec_regwe, use_a, use_b;

    always_comb begin
        dec_regwe = (opcode <= 4'd5) || ((opcode >= 4'd8) && (opcode <= 4'd11));
        use_a     = !((opcode == 4'd8) || ((opcode == 4'd12) && !flag));
        use_b     = (opcode <= 4'd4) || ((opcode >= 4'd9) && (opcode <= 4'd11)) || (opcode == 4'd13);
    end

    logic [DATA_W-1:0]  rf_reg [REG_CNT];
    logic [REG_CNT-1:0] busy_reg, busy_next, wb_clear, busy_eff;

    logic              valid_reg;
    logic [4:0]        aluop_reg;
    logic [DATA_W-1:0] data_a_reg, data_b_reg;
    logic [7:0]        imm_reg;
    logic [SEL_W-1:0]  seld_reg;
    logic              regwe_reg;

    always_comb begin
        wb_clear = '0;
        if (bus.I_wb_en)
            wb_clear[bus.I_wb_sel] = 1'b1;
    end

    // A register being written back this cycle is already safe to read via the bypass.
    assign busy_eff = busy_reg & ~wb_clear;

    logic hazard, ready, accept;

    assign hazard = (use_a && busy_eff[ra]) || (use_b && busy_eff[rb]) ||
                    (dec_regwe && busy_eff[rd]);
    assign ready  = I_rst_n && !bus.I_flush && !hazard && (!valid_reg || bus.I_ex_ready);
    assign accept = bus.I_instr_valid && ready;

    logic [DATA_W-1:0] operand_a, operand_b;

    assign operand_a = (bus.I_wb_en && (bus.I_wb_sel == ra)) ? bus.I_wb_data : rf_reg[ra];
    assign operand_b = (bus.I_wb_en && (bus.I_wb_sel == rb)) ? bus.I_wb_data : rf_reg[rb];

    genvar gi;
    generate
        for (gi = 0; gi < REG_CNT; gi++) begin : g_rf
            always_ff @(posedge I_clk or negedge I_rst_n) begin
                if (!I_rst_n)
                    rf_reg[gi] <= '0;
                else if (bus.I_wb_en && (bus.I_wb_sel == SEL_W'(gi)))
                    rf_reg[gi] <= bus.I_wb_data;
            end
        end
    endgenerate

    // Order matters: flush and writeback clear first, so a new reservation wins.
    always_comb begin
        busy_next = busy_reg;
        if (bus.I_flush && valid_reg && regwe_reg)
            busy_next[seld_reg] = 1'b0;
        busy_next = busy_next & ~wb_clear;
        if (accept && dec_regwe)
            busy_next[rd] = 1'b1;
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n)
            busy_reg <= '0;
        else
            busy_reg <= busy_next;
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            valid_reg  <= 1'b0;
            aluop_reg  <= '0;
            data_a_reg <= '0;
            data_b_reg <= '0;
            imm_reg    <= '0;
            seld_reg   <= '0;
            regwe_reg  <= 1'b0;
        end else if (accept) begin
            valid_reg  <= 1'b1;
            aluop_reg  <= {opcode, flag};
            data_a_reg <= operand_a;
            data_b_reg <= operand_b;
            imm_reg    <= imm;
            seld_reg   <= rd;
            regwe_reg  <= dec_regwe;
        end else if (bus.I_flush || bus.I_ex_ready) begin
            valid_reg  <= 1'b0;
        end
    end

    assign bus.o_instr_ready = ready;
    assign bus.o_valid       = valid_reg;
    assign bus.o_aluop       = aluop_reg;
    assign bus.o_dataA       = data_a_reg;
    assign bus.o_dataB       = data_b_reg;
    assign bus.o_imm         = imm_reg;
    assign bus.o_selD        = seld_reg;
    assign bus.o_regwe       = regwe_reg;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: scoreboard of expected issue-register
// contents plus scenario tasks for hazards, stalls, flushes and async reset.
module tb_decode_stage;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    decode_stage_if ifc ();

    decode_stage #(.DATA_W(16), .REG_CNT(8)) dut (
        .I_clk   (clk),
        .I_rst_n (rst_n),
        .bus     (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  aluop;
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  imm;
        logic [2:0]  seld;
        logic        regwe;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mregs [8];

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                       input logic fl, input logic [2:0] ra, input logic [2:0] rb);
        return {op, rd, fl, ra, rb, 2'b00};
    endfunction

    function automatic logic [15:0] mk_ld(input logic [2:0] rd, input logic [7:0] im);
        return {4'h8, rd, 1'b0, im};
    endfunction

    function automatic logic ref_regwe(input logic [3:0] op);
        return (op <= 4'd5) || (op >= 4'd8 && op <= 4'd11);
    endfunction

    function automatic logic [15:0] ref_read(input logic [2:0] idx);
        if (ifc.I_wb_en && ifc.I_wb_sel == idx) return ifc.I_wb_data;
        return mregs[idx];
    endfunction

    task automatic drive(input logic [15:0] instr, input logic vld, input logic exr,
                         input logic fl, input logic wben, input logic [2:0] sel,
                         input logic [15:0] data);
        ifc.I_instr       = instr;
        ifc.I_instr_valid = vld;
        ifc.I_ex_ready    = exr;
        ifc.I_flush       = fl;
        ifc.I_wb_en       = wben;
        ifc.I_wb_sel      = sel;
        ifc.I_wb_data     = data;
    endtask

    // One clock: sample at negedge, retire/compare consumed entry, queue accepted one.
    task automatic tick(output logic rdy);
        exp_t e;
        @(negedge clk);
        rdy = ifc.o_instr_ready;
        if (ifc.I_flush && ifc.o_valid) begin
            if (sb.size() > 0) void'(sb.pop_front());
        end else if (ifc.o_valid && ifc.I_ex_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_issue: got unexpected issue aluop=%h, required none", ifc.o_aluop);
            end else begin
                e = sb.pop_front();
                if ({ifc.o_aluop, ifc.o_dataA, ifc.o_dataB, ifc.o_imm, ifc.o_selD, ifc.o_regwe} !== e) begin
                    errors++;
                    $display("FAIL sb_issue: got %h/%h/%h/%h/%h/%b required %h/%h/%h/%h/%h/%b",
                             ifc.o_aluop, ifc.o_dataA, ifc.o_dataB, ifc.o_imm, ifc.o_selD, ifc.o_regwe,
                             e.aluop, e.a, e.b, e.imm, e.seld, e.regwe);
                end else begin
                    $display("txn aluop=%h a=%h b=%h imm=%h selD=%0d regwe=%b",
                             e.aluop, e.a, e.b, e.imm, e.seld, e.regwe);
                end
            end
        end
        if (ifc.I_instr_valid && rdy) begin
            e.aluop = {ifc.I_instr[15:12], ifc.I_instr[8]};
            e.a     = ref_read(ifc.I_instr[7:5]);
            e.b     = ref_read(ifc.I_instr[4:2]);
            e.imm   = ifc.I_instr[7:0];
            e.seld  = ifc.I_instr[11:9];
            e.regwe = ref_regwe(ifc.I_instr[15:12]);
            sb.push_back(e);
        end
        if (ifc.I_wb_en) mregs[ifc.I_wb_sel] = ifc.I_wb_data;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ifc.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", ifc.o_valid); end
        checks++;
        if ({ifc.o_aluop, ifc.o_dataA, ifc.o_dataB, ifc.o_imm, ifc.o_selD, ifc.o_regwe} !== 49'h0) begin
            errors++; $display("FAIL reset_outputs: got nonzero aluop=%h a=%h b=%h required 0", ifc.o_aluop, ifc.o_dataA, ifc.o_dataB);
        end
        checks++;
        if (ifc.o_instr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b required 0", ifc.o_instr_ready); end
        rst_n = 1'b1;
        #1;
        checks++;
        if (dut.busy_reg !== 8'h00) begin errors++; $display("FAIL reset_busy: got %h required 00", dut.busy_reg); end
    endtask

    task automatic test_load();
        logic rdy;
        drive(mk_ld(3'd1, 8'h34), 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
        tick(rdy);
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL load_ready: got %b required 1", rdy); end
        checks++;
        if ({ifc.o_valid, ifc.o_aluop, ifc.o_imm, ifc.o_selD, ifc.o_regwe} !== {1'b1, 5'h10, 8'h34, 3'd1, 1'b1}) begin
            errors++;
            $display("FAIL load_issue: got v=%b op=%h imm=%h sel=%0d we=%b required v=1 op=10 imm=34 sel=1 we=1",
                     ifc.o_valid, ifc.o_aluop, ifc.o_imm, ifc.o_selD, ifc.o_regwe);
        end
        checks++;
        if (dut.busy_reg !== 8'h02) begin errors++; $display("FAIL load_busy: got %h required 02", dut.busy_reg); end
    endtask

    task automatic test_raw_bypass();
        logic rdy;
        drive(mk(4'h0, 3'd2, 1'b0, 3'd1, 3'd1), 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
        for (int i = 0; i < 2; i++) begin
            tick(rdy);
            checks++;
            if (rdy !== 1'b0) begin errors++; $display("FAIL raw_stall[%0d]: got ready=%b required 0", i, rdy); end
        end
        drive(mk(4'h0, 3'd2, 1'b0, 3'd1, 3'd1), 1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 16'h0034);
        tick(rdy);
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL raw_release: got ready=%b required 1", rdy); end
        checks++;
        if ({ifc.o_dataA, ifc.o_dataB} !== {16'h0034, 16'h0034}) begin
            errors++; $display("FAIL raw_bypass: got a=%h b=%h required 0034/0034", ifc.o_dataA, ifc.o_dataB);
        end
        drive(16'h0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 16'h0068);
        tick(rdy);
        checks++;
        if (dut.busy_reg !== 8'h00) begin errors++; $display("FAIL raw_busy_clear: got %h required 00", dut.busy_reg); end
    endtask

    task automatic test_stall();
        logic rdy;
        exp_t e;
        drive(mk(4'h1, 3'd4, 1'b0, 3'd5, 3'd6), 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        tick(rdy);
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL stall_first: got ready=%b required 1", rdy); end
        drive(mk(4'h2, 3'd6, 1'b1, 3'd7, 3'd7), 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            tick(rdy);
            e = sb[0];
            checks++;
            if (rdy !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d]: got %b required 0", i, rdy); end
            checks++;
            if ({ifc.o_valid, ifc.o_aluop, ifc.o_dataA, ifc.o_dataB, ifc.o_imm, ifc.o_selD, ifc.o_regwe} !== {1'b1, e}) begin
                errors++; $display("FAIL stall_hold[%0d]: got v=%b op=%h sel=%0d required v=1 op=%h sel=%0d",
                                   i, ifc.o_valid, ifc.o_aluop, ifc.o_selD, e.aluop, e.seld);
            end
        end
        ifc.I_ex_ready = 1'b1;
        tick(rdy);
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL stall_resume: got ready=%b required 1", rdy); end
        checks++;
        if ({ifc.o_valid, ifc.o_aluop, ifc.o_selD} !== {1'b1, 5'h05, 3'd6}) begin
            errors++; $display("FAIL stall_next: got v=%b op=%h sel=%0d required v=1 op=05 sel=6", ifc.o_valid, ifc.o_aluop, ifc.o_selD);
        end
        drive(16'h0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 16'h1111);
        tick(rdy);
        drive(16'h0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd6, 16'h2222);
        tick(rdy);
        checks++;
        if (dut.busy_reg !== 8'h00) begin errors++; $display("FAIL stall_busy: got %h required 00", dut.busy_reg); end
    endtask

    task automatic test_jump_flush();
        logic rdy;
        drive(mk(4'hC, 3'd0, 1'b0, 3'd3, 3'd0), 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        tick(rdy);
        checks++;
        if ({rdy, ifc.o_valid, ifc.o_regwe} !== 3'b110) begin
            errors++; $display("FAIL jmp_issue: got rdy=%b v=%b we=%b required 1/1/0", rdy, ifc.o_valid, ifc.o_regwe);
        end
        checks++;
        if (dut.busy_reg !== 8'h00) begin errors++; $display("FAIL jmp_busy: got %h required 00", dut.busy_reg); end
        drive(mk(4'h3, 3'd7, 1'b0, 3'd1, 3'd2), 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0);
        tick(rdy);
        checks++;
        if (rdy !== 1'b0) begin errors++; $display("FAIL jmp_flush_ready: got %b required 0", rdy); end
        checks++;
        if (ifc.o_valid !== 1'b0) begin errors++; $display("FAIL jmp_flush_valid: got %b required 0", ifc.o_valid); end
    endtask

    task automatic test_flush_busy();
        logic rdy;
        logic [15:0] sub3;
        sub3 = mk(4'h1, 3'd3, 1'b0, 3'd1, 3'd2);
        drive(sub3, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        tick(rdy);
        checks++;
        if (dut.busy_reg !== 8'h08) begin errors++; $display("FAIL fl_busy_set: got %h required 08", dut.busy_reg); end
        drive(sub3, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0);
        tick(rdy);
        checks++;
        if ({rdy, ifc.o_valid, dut.busy_reg} !== {2'b00, 8'h00}) begin
            errors++; $display("FAIL fl_discard: got rdy=%b v=%b busy=%h required 0/0/00", rdy, ifc.o_valid, dut.busy_reg);
        end
        drive(sub3, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
        tick(rdy);
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL fl_reissue: got ready=%b required 1", rdy); end
        drive(16'h0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 16'h3333);
        tick(rdy);
    endtask

    task automatic test_set_wins();
        logic rdy;
        drive(mk_ld(3'd2, 8'h5A), 1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 16'h0202);
        tick(rdy);
        checks++;
        if ({rdy, dut.busy_reg} !== {1'b1, 8'h04}) begin
            errors++; $display("FAIL set_wins: got rdy=%b busy=%h required 1/04", rdy, dut.busy_reg);
        end
        drive(16'h0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 16'h0222);
        tick(rdy);
    endtask

    task automatic test_back_to_back();
        logic rdy;
        logic [15:0] prog [4];
        drive(16'h0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 16'hBEEF);
        tick(rdy);
        drive(16'h0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd7, 16'h1234);
        tick(rdy);
        prog[0] = mk(4'h3, 3'd0, 1'b0, 3'd5, 3'd7);
        prog[1] = mk(4'h4, 3'd1, 1'b1, 3'd7, 3'd5);
        prog[2] = mk(4'hE, 3'd2, 1'b1, 3'd5, 3'd5);
        prog[3] = mk(4'hD, 3'd0, 1'b0, 3'd5, 3'd7);
        for (int i = 0; i < 4; i++) begin
            drive(prog[i], 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
            tick(rdy);
            checks++;
            if ((rdy !== 1'b1) || (ifc.o_valid !== 1'b1)) begin
                errors++; $display("FAIL b2b[%0d]: got rdy=%b v=%b required 1/1", i, rdy, ifc.o_valid);
            end
        end
        drive(16'h0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 16'h0A0A);
        tick(rdy);
        drive(16'h0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 16'h0B0B);
        tick(rdy);
        checks++;
        if ({ifc.o_valid, dut.busy_reg} !== 9'h000) begin
            errors++; $display("FAIL b2b_drain: got v=%b busy=%h required 0/00", ifc.o_valid, dut.busy_reg);
        end
    endtask

    task automatic test_async_reset();
        logic rdy;
        logic [15:0] rf_or;
        for (int i = 0; i < 8; i++) begin
            drive(mk_ld(3'(i), 8'(8'h10 + i)), 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
            tick(rdy);
            checks++;
            if (rdy !== 1'b1) begin errors++; $display("FAIL ar_fill[%0d]: got ready=%b required 1", i, rdy); end
        end
        checks++;
        if ({ifc.o_valid, dut.busy_reg} !== {1'b1, 8'hFF}) begin
            errors++; $display("FAIL ar_pre: got v=%b busy=%h required 1/FF", ifc.o_valid, dut.busy_reg);
        end
        drive(16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
        #1 rst_n = 1'b0;
        #1;
        rf_or = 16'h0;
        for (int i = 0; i < 8; i++) rf_or = rf_or | dut.rf_reg[i];
        checks++;
        if ({ifc.o_valid, ifc.o_aluop, ifc.o_dataA, ifc.o_dataB, ifc.o_imm, ifc.o_selD, ifc.o_regwe} !== 50'h0) begin
            errors++; $display("FAIL ar_outputs: got v=%b op=%h a=%h sel=%0d required all 0", ifc.o_valid, ifc.o_aluop, ifc.o_dataA, ifc.o_selD);
        end
        checks++;
        if ({dut.busy_reg, rf_or} !== 24'h0) begin
            errors++; $display("FAIL ar_state: got busy=%h regs_or=%h required 00/0000", dut.busy_reg, rf_or);
        end
        #1 rst_n = 1'b1;
        sb.delete();
        for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
        drive(mk(4'h3, 3'd0, 1'b0, 3'd5, 3'd7), 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
        tick(rdy);
        checks++;
        if ({rdy, ifc.o_valid, ifc.o_dataA, ifc.o_dataB} !== {2'b11, 32'h0}) begin
            errors++; $display("FAIL ar_first_accept: got rdy=%b v=%b a=%h b=%h required 1/1/0000/0000",
                               rdy, ifc.o_valid, ifc.o_dataA, ifc.o_dataB);
        end
        drive(16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
        tick(rdy);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
        test_reset();
        test_load();
        test_raw_bypass();
        test_stall();
        test_jump_flush();
        test_flush_busy();
        test_set_wins();
        test_back_to_back();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d pending entries required 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DATA_W, default 16, register and operand width; only the default is supported and verified.
REQ-002 Parameter REG_CNT, default 8, number of general registers; only the default is supported and verified.
REQ-003 I_clk  in  1  single clock; all state updates on posedge I_clk.
REQ-004 I_rst_n  in  1  asynchronous, active-low reset.
REQ-005 I_instr  in  16  instruction word.
REQ-006 I_instr_valid  in  1  I_instr valid.
REQ-007 o_instr_ready  out  1  decode can accept I_instr this cycle.
REQ-008 I_ex_ready  in  1  execute stage consumes the output register this cycle.
REQ-009 I_flush  in  1  branch taken; discard the output register contents.
REQ-010 I_wb_en, I_wb_sel[2:0], I_wb_data[15:0]  in  writeback port into the register file.
REQ-011 o_valid  out  1  output register holds a decoded instruction; drives ALU I_en.
REQ-012 o_aluop[4:0], o_dataA[15:0], o_dataB[15:0], o_imm[7:0]  out  ALU operands.
REQ-013 o_selD[2:0], o_regwe  out  destination register and write flag, carried to writeback.

Function
REQ-014 Instruction fields: opcode=I_instr[15:12], rD=[11:9], flag=[8], rA=[7:5], rB=[4:2], imm=[7:0]; o_aluop={opcode,flag}.
REQ-015 regwe=1 for opcodes 0-5 and 8-11; regwe=0 for 12-13 (jumps) and 6,7,14,15 (no-op).
REQ-016 rA is used by every opcode except 8 (Load) and 12 with flag=0; rB is used by opcodes 0-4, 9-11 and 13; unused fields never cause stalls.
REQ-017 Register file: 8x16 registers, no hardwired zero; written on posedge when I_wb_en=1.
REQ-018 Read bypass: when I_wb_en=1 and I_wb_sel equals a read index in the same cycle, the operand captured is I_wb_data.
REQ-019 Scoreboard: busy[7:0]; set busy[rD] on accept with regwe=1; clear busy[I_wb_sel] on I_wb_en=1.
REQ-020 Simultaneous set and clear of the same bit: set wins.
REQ-021 Hazard = used rA busy, OR used rB busy, OR (regwe AND busy[rD]); a bit cleared by I_wb_en in the same cycle counts as not busy.
REQ-022 o_instr_ready = I_rst_n AND !I_flush AND !hazard AND (!o_valid OR I_ex_ready); combinational; may depend on I_instr.
REQ-023 Accept = I_instr_valid AND o_instr_ready; on accept, the output register loads the decoded fields and operands, and o_valid=1 on the next cycle (1-cycle latency).
REQ-024 o_valid=1 AND I_ex_ready=1 AND no accept -> o_valid=0 on the next cycle; consume plus accept in the same cycle gives back-to-back issue.
REQ-025 While o_valid=1 AND I_ex_ready=0, all outputs hold stable.
REQ-026 I_flush=1 -> o_valid=0 on the next cycle; if the flushed entry had o_regwe=1, clear busy[o_selD] (wb set/clear rules still apply); no accept occurs in that cycle.
REQ-027 I_flush with o_valid=0 -> no effect other than blocking accept.

Reset
REQ-028 I_rst_n=0 immediately forces o_valid=0, busy=0, all 8 registers=0, and o_aluop, o_dataA, o_dataB, o_imm, o_selD, o_regwe=0, regardless of I_clk.
REQ-029 Reset asserted mid-operation discards the in-flight entry; the first accept is allowed on the first posedge after I_rst_n rises.

Verification
REQ-030 Reset, then Load r1 (0x8 rD=1 flag=0 imm=0x34) with I_ex_ready=1 -> next cycle o_valid=1, o_aluop=0x10, o_imm=0x34, o_selD=1, o_regwe=1, busy[1]=1.
REQ-031 Add r2=r1+r1 issued while busy[1]=1 -> o_instr_ready=0 until I_wb_en=1, I_wb_sel=1, I_wb_data=0x0034; issue in that cycle -> o_dataA=o_dataB=0x0034.
REQ-032 I_ex_ready=0 for 3 cycles with o_valid=1 and a valid instruction pending -> outputs stable, o_instr_ready=0; I_ex_ready=1 -> pending instruction issues in the next cycle.
REQ-033 JMPA (0xC, flag=0) issued -> o_regwe=0, busy unchanged; I_flush in the next cycle -> o_valid=0 and no accept in the flush cycle.
REQ-034 Accept Sub r3, then I_flush before consume -> busy[3]=0 and o_valid=0 on the next cycle; an immediately following Sub r3 issues without stall.
REQ-035 I_rst_n pulsed low asynchronously (between clock edges) with o_valid=1 and busy=0xFF -> all outputs and busy read 0 before the next posedge.
